// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity helper and line
// idle level, used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Level of an idle UART line (mark).
    localparam logic UART_IDLE = 1'b1;

    // Widest data word the parity helper accepts; narrower words are
    // zero-extended by the caller, which leaves the XOR unchanged.
    localparam int UART_MAX_DATA_BITS = 9;

    // Parity bit a transmitter appends for the given word.
    function automatic logic calc_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
module uart_bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the input through two stages.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchroniser stages; reset to the inactive line level.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // two stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: synchronises rx_serial, qualifies the start bit at its
// centre, then samples data, optional parity and stop at bit centres.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 busy_q, busy_d;

    logic                 tick;
    logic                 parity_ok;

    uart_bit_sync #(
        .RESET_VAL (UART_IDLE)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_serial),
        .sync_out (rx_s)
    );

    // Sample point: half a bit after the start edge, then every full bit.
    assign tick = (state_q == START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

    assign parity_ok = (PARITY_EN == 0) ||
                       (par_q == calc_parity(UART_MAX_DATA_BITS'(shift_q), PARITY_ODD != 0));

    // State register and datapath registers.
    // NOTE: rx_data must be reset because a reset mid-frame has to clear the
    // last word; the shift register is reset only to keep simulation X-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (tick) state_d = rx_s ? IDLE : DATA;
            DATA:    if (tick && idx_q == IDX_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, sampling and result pulses.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        // Busy is registered from the state, so it follows the state by one
        // cycle on both rising and falling edges.
        busy_d  = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START: begin
                if (tick) cnt_d = '0;
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_d = '0;
                    par_d = rx_s;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        // A framing error masks any parity result.
                        ferr_d = 1'b1;
                    end else if (parity_ok) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign rx_data    = data_q;
    assign rx_done    = done_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: a default instance (no parity)
// and a parity instance (even parity), driven by directed frames, a vector
// table and random frames checked against a frame-level model.
module tb_uart_rx_sampler;

    localparam int C     = 16;
    localparam int LAT_A = 2 + C / 2 + (8 + 0 + 1) * C;   // 154
    localparam int LAT_B = 2 + C / 2 + (8 + 1 + 1) * C;   // 170

    localparam int K_DONE = 1;
    localparam int K_FERR = 2;
    localparam int K_PERR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       done_a, ferr_a, perr_a, busy_a;
    logic       done_b, ferr_b, perr_b, busy_b;

    uart_rx_sampler dut_a (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_a),
        .rx_data    (data_a),
        .rx_done    (done_a),
        .frame_err  (ferr_a),
        .parity_err (perr_a),
        .rx_busy    (busy_a)
    );

    uart_rx_sampler #(
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_b),
        .rx_data    (data_b),
        .rx_done    (done_b),
        .frame_err  (ferr_b),
        .parity_err (perr_b),
        .rx_busy    (busy_b)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed result pulses, one queue per instance.
    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    ev_t  q_a[$];
    ev_t  q_b[$];
    int   rise_a = 0, fall_a = 0;
    logic busy_prev_a = 1'b0;

    always @(negedge clk) begin
        if (done_a || ferr_a || perr_a) begin
            check("onehot_a", 32'(done_a) + 32'(ferr_a) + 32'(perr_a), 1);
            q_a.push_back('{kind: done_a ? K_DONE : (ferr_a ? K_FERR : K_PERR),
                            cyc: cyc, data: int'(data_a)});
        end
        if (busy_a && !busy_prev_a) rise_a = cyc;
        if (!busy_a && busy_prev_a) fall_a = cyc;
        busy_prev_a = busy_a;
    end

    always @(negedge clk) begin
        if (done_b || ferr_b || perr_b) begin
            check("onehot_b", 32'(done_b) + 32'(ferr_b) + 32'(perr_b), 1);
            q_b.push_back('{kind: done_b ? K_DONE : (ferr_b ? K_FERR : K_PERR),
                            cyc: cyc, data: int'(data_b)});
        end
    end

    // Hold a level on the selected line for n clock cycles (called just
    // after a falling edge, returns just after a falling edge).
    task automatic put(input int sel, input logic v, input int n);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; par_mode < 0 means no parity bit. e0 is the rising
    // edge at which the start bit is first sampled.
    task automatic send_frame(input int sel, input logic [7:0] d, input int par_mode,
                              input logic stop_v, input int stop_len, output int e0);
        e0 = cyc + 1;
        put(sel, 1'b0, C);
        for (int i = 0; i < 8; i++) put(sel, d[i], C);
        if (par_mode >= 0) put(sel, par_mode[0], C);
        put(sel, stop_v, stop_len);
    endtask

    // Pop the next pulse and compare kind, latency from e0, and rx_data.
    task automatic wait_event(input int sel, input int kind, input int e0, input int lat,
                              input int exp_data, input string name, output int got_cyc);
        ev_t ev;
        bit  got = 0;
        got_cyc = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            if (sel == 0 && q_a.size() > 0) begin
                ev = q_a.pop_front(); got = 1;
            end else if (sel == 1 && q_b.size() > 0) begin
                ev = q_b.pop_front(); got = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            got_cyc = ev.cyc;
            check({name, "_kind"}, ev.kind, kind);
            check({name, "_lat"},  ev.cyc - e0, lat);
            check({name, "_data"}, ev.data, exp_data);
        end
    endtask

    task automatic quiet(input int sel, input string name);
        check(name, (sel == 0) ? q_a.size() : q_b.size(), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        int         par;
        logic       stop;
        int         kind;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int         e0, c0, c1, c2, dummy;
        logic [7:0] good_a, good_b, d;
        bit         bad;
        int         gap;

        good_a = 8'h00;
        good_b = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_a", data_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_ferr_a", ferr_a, 0);
        check("rst_perr_a", perr_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_data_b", data_b, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic frame 0xA5 with busy timing
        send_frame(0, 8'hA5, -1, 1'b1, C, e0);
        wait_event(0, K_DONE, e0, LAT_A, 8'hA5, "a5", dummy);
        good_a = 8'hA5;
        check("a5_busy_rise", rise_a - e0, 3);
        check("a5_busy_fall", fall_a - e0, LAT_A + 1);
        put(0, 1'b1, 4);
        check("a5_busy_low", busy_a, 0);

        // Half-bit glitch, then a real frame
        e0 = cyc + 1;
        put(0, 1'b0, C / 2);
        put(0, 1'b1, 24);
        quiet(0, "glitch_quiet");
        check("glitch_busy_fall", (fall_a > e0) && (fall_a - e0 <= 12), 1);
        check("glitch_busy_low", busy_a, 0);
        send_frame(0, 8'h3C, -1, 1'b1, C, e0);
        wait_event(0, K_DONE, e0, LAT_A, 8'h3C, "x3c", dummy);
        good_a = 8'h3C;
        put(0, 1'b1, 4);

        // Stop bit low followed by a 40-bit break
        send_frame(0, 8'h5A, -1, 1'b0, C + 40 * C, e0);
        put(0, 1'b1, 32);
        wait_event(0, K_FERR, e0, LAT_A, good_a, "brk", dummy);
        quiet(0, "brk_single");
        check("brk_data_held", data_a, good_a);
        send_frame(0, 8'h81, -1, 1'b1, C, e0);
        wait_event(0, K_DONE, e0, LAT_A, 8'h81, "x81", dummy);
        good_a = 8'h81;
        put(0, 1'b1, 4);

        // Even parity instance: good and bad parity on 0x07
        send_frame(1, 8'h07, 1, 1'b1, C, e0);
        wait_event(1, K_DONE, e0, LAT_B, 8'h07, "par_good", dummy);
        good_b = 8'h07;
        put(1, 1'b1, 4);
        send_frame(1, 8'h07, 0, 1'b1, C, e0);
        wait_event(1, K_PERR, e0, LAT_B, good_b, "par_bad", dummy);
        put(1, 1'b1, 4);

        // Three back-to-back frames
        send_frame(0, 8'h00, -1, 1'b1, C, e0);
        wait_event(0, K_DONE, e0, LAT_A, 8'h00, "b2b0", c0);
        send_frame(0, 8'hFF, -1, 1'b1, C, e0);
        wait_event(0, K_DONE, e0, LAT_A, 8'hFF, "b2b1", c1);
        send_frame(0, 8'h55, -1, 1'b1, C, e0);
        wait_event(0, K_DONE, e0, LAT_A, 8'h55, "b2b2", c2);
        check("b2b_gap01", c1 - c0, 10 * C);
        check("b2b_gap12", c2 - c1, 10 * C);
        good_a = 8'h55;
        put(0, 1'b1, 4);

        // Reset 50 cycles into frame 0xC3 (bits LSB first: 1,1,0,...)
        put(0, 1'b0, C);
        put(0, 1'b1, C);
        put(0, 1'b1, C);
        put(0, 1'b0, 2);
        rst = 1'b1;
        put(0, 1'b1, 3);
        rst = 1'b0;
        put(0, 1'b1, 20 + LAT_A);
        quiet(0, "rst_quiet_a");
        quiet(1, "rst_quiet_b");
        check("rst_mid_data_a", data_a, 0);
        check("rst_mid_data_b", data_b, 0);
        check("rst_mid_busy_a", busy_a, 0);
        good_a = 8'h00;
        good_b = 8'h00;
        send_frame(0, 8'h12, -1, 1'b1, C, e0);
        wait_event(0, K_DONE, e0, LAT_A, 8'h12, "x12", dummy);
        good_a = 8'h12;
        put(0, 1'b1, 4);

        // Vector table on the parity instance
        tbl[0] = '{8'h00, 0, 1'b1, K_DONE};
        tbl[1] = '{8'h00, 1, 1'b1, K_PERR};
        tbl[2] = '{8'hFF, 0, 1'b1, K_DONE};
        tbl[3] = '{8'h80, 1, 1'b1, K_DONE};
        tbl[4] = '{8'h80, 0, 1'b1, K_PERR};
        tbl[5] = '{8'hC3, 1, 1'b0, K_FERR};
        tbl[6] = '{8'hFE, 1, 1'b1, K_DONE};
        for (int i = 0; i < 7; i++) begin
            send_frame(1, tbl[i].d, tbl[i].par, tbl[i].stop, C, e0);
            put(1, 1'b1, 6);
            wait_event(1, tbl[i].kind, e0, LAT_B,
                       (tbl[i].kind == K_DONE) ? int'(tbl[i].d) : int'(good_b),
                       $sformatf("vec%0d", i), dummy);
            if (tbl[i].kind == K_DONE) good_b = tbl[i].d;
        end

        // Random frames on the default instance against the frame model
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(bad ? 4 : 0, 20);
            send_frame(0, d, -1, !bad, C, e0);
            wait_event(0, bad ? K_FERR : K_DONE, e0, LAT_A,
                       bad ? int'(good_a) : int'(d), $sformatf("rnd%0d", i), dummy);
            if (!bad) good_a = d;
            put(0, 1'b1, gap);
        end

        put(0, 1'b1, 200);
        quiet(0, "end_quiet_a");
        quiet(1, "end_quiet_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

- Standalone UART receiver: recovers bytes from the asynchronous `rx_serial` line driven by a remote transmitter.
- Receive counterpart of the existing transmit path in `uartprotocoltop`; replaces the ideal loopback receiver in the top level.
- Synchronises the line, qualifies the start bit with a mid-bit sample, then samples data, optional parity and stop bits at bit centre.
- Reports a good frame with `rx_done`; reports framing or parity errors with dedicated pulses.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clocks per bit period. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–9.
- `PARITY_EN`, default 0: 1 adds one parity bit after the data bits.
- `PARITY_ODD`, default 0: parity sense when `PARITY_EN`=1. 0 = even, 1 = odd.

Ports:
- `clk` in, 1: the single clock.
- `rst` in, 1: reset. One clock; reset is asynchronous and active-high.
- `rx_serial` in, 1: asynchronous serial line. Idle high; LSB first.
- `rx_data` out, `DATA_BITS`: last good received word. Held until the next good frame.
- `rx_done` out, 1: one-cycle pulse; `rx_data` is valid in the same cycle.
- `frame_err` out, 1: one-cycle pulse; stop bit sampled low.
- `parity_err` out, 1: one-cycle pulse; parity mismatch, stop bit good.
- `rx_busy` out, 1: high in every state except IDLE.

## Operation

- `rx_serial` passes through a 2-flop synchroniser giving `rx_s`. Both flops reset to 1.
- States and transitions:
  - IDLE: on `rx_s`=0, clear the bit counter and go to START.
  - START: count `CLKS_PER_BIT/2` cycles, then sample. If 0, go to DATA. If 1 (glitch), return to IDLE with no output pulse.
  - DATA: every `CLKS_PER_BIT` cycles, sample into the shift register, LSB first. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`=1, else to STOP.
  - PARITY: after `CLKS_PER_BIT` cycles, sample and compare against the XOR of the data bits, inverted when `PARITY_ODD`=1.
  - STOP: after `CLKS_PER_BIT` cycles, sample, then:
    - sample 1, parity good or disabled: load `rx_data`, pulse `rx_done`, go to IDLE.
    - sample 1, parity bad: pulse `parity_err`, leave `rx_data` unchanged, go to IDLE.
    - sample 0: pulse `frame_err` only (`parity_err` suppressed), leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line (break) therefore produces exactly one `frame_err`.
- At most one of `rx_done`, `frame_err`, `parity_err` is high in any cycle.
- Counter width is `$clog2(CLKS_PER_BIT)`. The bit index wraps at `DATA_BITS` and is never compared beyond it.

## Timing

- Reset values: `rx_data`=0, `rx_done`=0, `frame_err`=0, `parity_err`=0, `rx_busy`=0, state IDLE.
- Reset mid-frame aborts the frame immediately. No pulse is issued and `rx_data` is cleared to 0.
- Latency definitions:
  - E0 = first rising edge of `clk` at which `rx_serial` is sampled low.
  - P = `PARITY_EN`.
  - L = 2 + `CLKS_PER_BIT/2` + (`DATA_BITS`+P+1)·`CLKS_PER_BIT`.
- The result pulse is high in the cycle that begins exactly L cycles after E0.
- `rx_busy` rises 3 cycles after E0 and falls in the cycle after the result pulse (later when leaving through BREAK).
- Back-to-back frames: a start edge arriving in the second half of the stop bit is detected normally, with no lost frame.
- No flow control. An unread `rx_data` is overwritten by the next good frame.

## Structure

- Shared package `uart_pkg` holds:
  - `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the `calc_parity(data, odd)` function;
  - the idle-level constant `UART_IDLE = 1'b1`, also used by the transmit side.
- Sub-module `uart_bit_sync`: a 2-flop synchroniser with a reset-value parameter, instantiated with reset value 1.

## Test plan

Common settings: `clk` period 20 ns, defaults unless stated. Frame time is 16 cycles/bit; L = 154.

- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → `rx_done` exactly 154 cycles after E0; `rx_data`=0xA5; no error pulses; `rx_busy` low afterwards.
- 0.5-bit-period low glitch (8 cycles) on idle line → no pulse of any kind; `rx_busy` returns low within 12 cycles; a following 0x3C frame is received correctly.
- Frame 0x5A with stop bit forced low, then line held low for 40 bit periods → one `frame_err`, no `rx_done`, `rx_data` keeps its previous value; next frame 0x81 after line release → `rx_done`, 0x81.
- Parity build, `PARITY_EN`=1, `PARITY_ODD`=0 (L = 170): frame 0x07 with parity 1 → `rx_done` at cycle 170; same frame with parity 0 → `parity_err` only.
- Three back-to-back frames 0x00, 0xFF, 0x55, each start edge 8 cycles after the previous stop sample → three `rx_done` pulses, exactly 160 cycles apart, with the correct data each time.
- `rst` asserted 50 cycles into frame 0xC3, released after 3 cycles, line returned high → no pulse; `rx_data`=0; the next frame 0x12 is received correctly.
